// File: rtl/dispatch_stage.sv
// rtl/dispatch_stage.sv - in-order dispatch: NOP squash, resource-limited packing, ROB tag allocation (optional DISPATCH_PERF_EN counters)
module dispatch_stage #(
    parameter int WIDTH     = 2,
    parameter int ROB_DEPTH = 32,
    parameter int TAG_W     = $clog2(ROB_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         ifq_valid,
    input  logic [32*WIDTH-1:0]      ifq_instr,
    input  logic [32*WIDTH-1:0]      ifq_pc,
    output logic [2:0]               ifq_pop,
    input  logic [TAG_W:0]           rob_free_cnt,
    input  logic [2:0]               rs_free_cnt,
    input  logic                     flush,
    input  logic [TAG_W-1:0]         flush_tail,
    output logic [WIDTH-1:0]         disp_valid,
    output logic [32*WIDTH-1:0]      disp_instr,
    output logic [32*WIDTH-1:0]      disp_pc,
    output logic [TAG_W*WIDTH-1:0]   disp_tag,
    input  logic                     disp_ready
`ifdef DISPATCH_PERF_EN
    ,
    output logic [31:0]              stall_rob_cnt,
    output logic [31:0]              stall_rs_cnt,
    output logic [31:0]              nop_drop_cnt
`endif
);

    logic [TAG_W-1:0]       tail;
    logic                   load_ok;
    logic                   stopped;
    int                     lim;
    int                     acc_n;
    int                     pop_n;
    logic [WIDTH-1:0]       nxt_valid;
    logic [32*WIDTH-1:0]    nxt_instr;
    logic [32*WIDTH-1:0]    nxt_pc;
    logic [TAG_W*WIDTH-1:0] nxt_tag;
`ifdef DISPATCH_PERF_EN
    int                     nop_n;
    logic                   stop_rob;
    logic                   stop_rs;
`endif

    function automatic logic is_nop(input logic [31:0] w);
        return (w == 32'h00000013) || (w == 32'h00000000);
    endfunction

    // The output register can take a new bundle when empty or draining now.
    assign load_ok = !disp_valid[0] || disp_ready;

    // In-order scan: NOPs are consumed for free, real instructions are packed
    // into lanes until the tightest of ROB/RS/lane budget is exhausted.
    always_comb begin
        stopped   = 1'b0;
        acc_n     = 0;
        pop_n     = 0;
        nxt_instr = '0;
        nxt_pc    = '0;
        nxt_tag   = '0;
        nxt_valid = '0;
`ifdef DISPATCH_PERF_EN
        nop_n     = 0;
        stop_rob  = 1'b0;
        stop_rs   = 1'b0;
`endif
        lim = WIDTH;
        if (int'(rob_free_cnt) < lim) lim = int'(rob_free_cnt);
        if (int'(rs_free_cnt) < lim)  lim = int'(rs_free_cnt);
        for (int i = 0; i < WIDTH; i++) begin
            if (!stopped) begin
                if (!ifq_valid[i]) begin
                    stopped = 1'b1;
                end else if (is_nop(ifq_instr[32*i +: 32])) begin
                    pop_n = pop_n + 1;
`ifdef DISPATCH_PERF_EN
                    nop_n = nop_n + 1;
`endif
                end else if (acc_n < lim) begin
                    nxt_instr[32*acc_n +: 32]       = ifq_instr[32*i +: 32];
                    nxt_pc[32*acc_n +: 32]          = ifq_pc[32*i +: 32];
                    nxt_tag[TAG_W*acc_n +: TAG_W]   = tail + TAG_W'(acc_n);
                    acc_n = acc_n + 1;
                    pop_n = pop_n + 1;
                end else begin
                    stopped = 1'b1;
`ifdef DISPATCH_PERF_EN
                    if (acc_n >= int'(rob_free_cnt))     stop_rob = 1'b1;
                    else if (acc_n >= int'(rs_free_cnt)) stop_rs  = 1'b1;
`endif
                end
            end
        end
        for (int k = 0; k < WIDTH; k++) begin
            nxt_valid[k] = (k < acc_n);
        end
    end

    // Pop only on a real load cycle; reset and flush suppress it immediately.
    assign ifq_pop = (rst && load_ok && !flush) ? 3'(pop_n) : 3'd0;

    // Output bundle register and ROB tail; flush beats load, empty loads keep payload.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_valid <= '0;
            disp_instr <= '0;
            disp_pc    <= '0;
            disp_tag   <= '0;
            tail       <= '0;
        end else if (flush) begin
            disp_valid <= '0;
            tail       <= flush_tail;
        end else if (load_ok) begin
            disp_valid <= nxt_valid;
            if (acc_n != 0) begin
                disp_instr <= nxt_instr;
                disp_pc    <= nxt_pc;
                disp_tag   <= nxt_tag;
            end
            tail <= tail + TAG_W'(acc_n);
        end
    end

`ifdef DISPATCH_PERF_EN
    // Saturating stall and NOP-drop counters, sampled only on real scan cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_rob_cnt <= '0;
            stall_rs_cnt  <= '0;
            nop_drop_cnt  <= '0;
        end else if (!flush && load_ok) begin
            if (stop_rob && stall_rob_cnt != 32'hFFFF_FFFF) stall_rob_cnt <= stall_rob_cnt + 32'd1;
            if (stop_rs && stall_rs_cnt != 32'hFFFF_FFFF)   stall_rs_cnt  <= stall_rs_cnt + 32'd1;
            if (32'hFFFF_FFFF - nop_drop_cnt < 32'(nop_n))   nop_drop_cnt  <= 32'hFFFF_FFFF;
            else                                             nop_drop_cnt  <= nop_drop_cnt + 32'(nop_n);
        end
    end
`endif

endmodule

// File: tb/tb_dispatch_stage.sv
// tb/tb_dispatch_stage.sv - directed self-checking bench for dispatch_stage
module tb_dispatch_stage;
    localparam int WIDTH     = 2;
    localparam int ROB_DEPTH = 32;
    localparam int TAG_W     = 5;

    localparam logic [31:0] ADDI0 = 32'h00100093;
    localparam logic [31:0] ADDI1 = 32'h00200113;
    localparam logic [31:0] ADD   = 32'h002081b3;
    localparam logic [31:0] NOP   = 32'h00000013;
    localparam logic [31:0] PC0   = 32'h00001000;
    localparam logic [31:0] PC1   = 32'h00001004;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic [WIDTH-1:0]       ifq_valid;
    logic [32*WIDTH-1:0]    ifq_instr;
    logic [32*WIDTH-1:0]    ifq_pc;
    logic [2:0]             ifq_pop;
    logic [TAG_W:0]         rob_free_cnt;
    logic [2:0]             rs_free_cnt;
    logic                   flush;
    logic [TAG_W-1:0]       flush_tail;
    logic [WIDTH-1:0]       disp_valid;
    logic [32*WIDTH-1:0]    disp_instr;
    logic [32*WIDTH-1:0]    disp_pc;
    logic [TAG_W*WIDTH-1:0] disp_tag;
    logic                   disp_ready;

    int errors = 0;
    int checks = 0;

    dispatch_stage #(.WIDTH(WIDTH), .ROB_DEPTH(ROB_DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .ifq_valid    (ifq_valid),
        .ifq_instr    (ifq_instr),
        .ifq_pc       (ifq_pc),
        .ifq_pop      (ifq_pop),
        .rob_free_cnt (rob_free_cnt),
        .rs_free_cnt  (rs_free_cnt),
        .flush        (flush),
        .flush_tail   (flush_tail),
        .disp_valid   (disp_valid),
        .disp_instr   (disp_instr),
        .disp_pc      (disp_pc),
        .disp_tag     (disp_tag),
        .disp_ready   (disp_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                         input logic [5:0] rob, input logic [2:0] rs, input logic rdy);
        ifq_valid    = v;
        ifq_instr    = {i1, i0};
        ifq_pc       = {PC1, PC0};
        rob_free_cnt = rob;
        rs_free_cnt  = rs;
        disp_ready   = rdy;
        flush        = 1'b0;
        flush_tail   = '0;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(2'b11, ADDI0, ADDI1, 6'd8, 3'd4, 1'b1);
        #1;
        check("reset_valid", disp_valid, 2'b00);
        check("reset_tag", disp_tag, 10'd0);
        check("reset_instr", disp_instr, 64'd0);
        check("reset_pop", ifq_pop, 3'd0);
        #2 rst = 1'b1;
        #1;
        // two addi, plenty of resources
        check("a_pop", ifq_pop, 3'd2);
        tick;
        check("a_valid", disp_valid, 2'b11);
        check("a_tag", disp_tag, {5'd1, 5'd0});
        check("a_instr", disp_instr, {ADDI1, ADDI0});
        check("a_pc", disp_pc, {PC1, PC0});
        // NOP in slot0 is popped but not allocated
        drive(2'b11, NOP, ADD, 6'd8, 3'd4, 1'b1);
        #1 check("b_pop", ifq_pop, 3'd2);
        tick;
        check("b_valid", disp_valid, 2'b01);
        check("b_instr0", disp_instr[31:0], ADD);
        check("b_tag0", disp_tag[4:0], 5'd2);
        // ROB limits to one
        drive(2'b11, ADDI0, ADDI1, 6'd1, 3'd4, 1'b1);
        #1 check("c_pop", ifq_pop, 3'd1);
        tick;
        check("c_valid", disp_valid, 2'b01);
        check("c_instr0", disp_instr[31:0], ADDI0);
        check("c_tag0", disp_tag[4:0], 5'd3);
        // hold for three cycles
        drive(2'b11, ADD, ADDI1, 6'd8, 3'd4, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1 check("hold_pop", ifq_pop, 3'd0);
            tick;
            check("hold_valid", disp_valid, 2'b01);
            check("hold_instr0", disp_instr[31:0], ADDI0);
            check("hold_tag0", disp_tag[4:0], 5'd3);
        end
        disp_ready = 1'b1;
        #1 check("rel_pop", ifq_pop, 3'd2);
        tick;
        check("rel_valid", disp_valid, 2'b11);
        check("rel_tag", disp_tag, {5'd5, 5'd4});
        check("rel_instr", disp_instr, {ADDI1, ADD});
        // flush while held
        drive(2'b11, ADDI0, ADDI1, 6'd8, 3'd4, 1'b0);
        flush = 1'b1;
        flush_tail = 5'd9;
        #1 check("flush_pop", ifq_pop, 3'd0);
        tick;
        check("flush_valid", disp_valid, 2'b00);
        drive(2'b11, ADDI0, ADDI1, 6'd8, 3'd4, 1'b1);
        #1 check("pf_pop", ifq_pop, 3'd2);
        tick;
        check("pf_valid", disp_valid, 2'b11);
        check("pf_tag", disp_tag, {5'd10, 5'd9});
        // wrap from tail 31
        drive(2'b11, ADDI0, ADDI1, 6'd8, 3'd4, 1'b1);
        flush = 1'b1;
        flush_tail = 5'd31;
        tick;
        check("f31_valid", disp_valid, 2'b00);
        drive(2'b11, ADDI0, ADDI1, 6'd8, 3'd4, 1'b1);
        tick;
        check("wrap_tag", disp_tag, {5'd0, 5'd31});
        drive(2'b01, ADD, ADDI1, 6'd8, 3'd4, 1'b1);
        #1 check("one_pop", ifq_pop, 3'd1);
        tick;
        check("one_valid", disp_valid, 2'b01);
        check("one_tag0", disp_tag[4:0], 5'd1);
        // empty load drains
        drive(2'b00, ADD, ADDI1, 6'd8, 3'd4, 1'b1);
        #1 check("empty_pop", ifq_pop, 3'd0);
        tick;
        check("empty_valid", disp_valid, 2'b00);
        // NOP-only load
        drive(2'b01, NOP, ADDI1, 6'd8, 3'd4, 1'b1);
        #1 check("noponly_pop", ifq_pop, 3'd1);
        tick;
        check("noponly_valid", disp_valid, 2'b00);
        // non-contiguous valid stops at slot 0
        drive(2'b10, ADDI0, ADDI1, 6'd8, 3'd4, 1'b1);
        #1 check("gap_pop", ifq_pop, 3'd0);
        tick;
        check("gap_valid", disp_valid, 2'b00);
        // no RS: zero-word NOP popped, stop at add
        drive(2'b11, 32'h0, ADD, 6'd8, 3'd0, 1'b1);
        #1 check("rs0_pop", ifq_pop, 3'd1);
        tick;
        check("rs0_valid", disp_valid, 2'b00);
        drive(2'b11, ADDI0, ADDI1, 6'd8, 3'd4, 1'b1);
        tick;
        check("after_tag", disp_tag, {5'd3, 5'd2});
        // reset mid-bundle
        drive(2'b11, ADDI0, ADDI1, 6'd8, 3'd4, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("rst_valid", disp_valid, 2'b00);
        check("rst_tag", disp_tag, 10'd0);
        check("rst_pop", ifq_pop, 3'd0);
        rst = 1'b1;
        disp_ready = 1'b1;
        tick;
        check("rst_reload_tag", disp_tag, {5'd1, 5'd0});
        check("rst_reload_valid", disp_valid, 2'b11);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
